// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - op codes, FSM states and default latencies for the HI/LO unit
package muldiv_sequencer_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] MT_DISABLED = 4'd0;
  localparam logic [OP_W-1:0] MT_MULT     = 4'd1;
  localparam logic [OP_W-1:0] MT_MULTU    = 4'd2;
  localparam logic [OP_W-1:0] MT_DIV      = 4'd3;
  localparam logic [OP_W-1:0] MT_DIVU     = 4'd4;
  localparam logic [OP_W-1:0] MT_MADD     = 4'd5;
  localparam logic [OP_W-1:0] MT_MADDU    = 4'd6;
  localparam logic [OP_W-1:0] MT_MSUB     = 4'd7;
  localparam logic [OP_W-1:0] MT_SET_HI   = 4'd8;
  localparam logic [OP_W-1:0] MT_SET_LO   = 4'd9;

  localparam int DEFAULT_MUL_LATENCY = 5;
  localparam int DEFAULT_DIV_LATENCY = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } muldiv_state_t;

  // Codes outside the table behave exactly like MT_DISABLED.
  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    return (op >= MT_MULT) && (op <= MT_SET_LO);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MT_DIV) || (op == MT_DIVU);
  endfunction

  function automatic logic is_multicycle_op(input logic [OP_W-1:0] op);
    return (op >= MT_MULT) && (op <= MT_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - combinational product, accumulate and divide for HI/LO commit
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic        b_zero;
  logic        s_ovf;
  logic [31:0] b_safe;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign acc    = {hi_in, lo_in};

  // The divider never sees a zero divisor or the INT_MIN/-1 pair; those
  // cases are resolved by the fixed results below, so a divisor of 1 is safe.
  assign b_zero = (b == 32'd0);
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe = (b_zero || s_ovf) ? 32'd1 : b;
  assign sq     = $signed(a) / $signed(b_safe);
  assign sr     = $signed(a) % $signed(b_safe);
  assign uq     = a / b_safe;
  assign ur     = a % b_safe;

  // Select the committed {hi,lo} for the latched op
  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    case (op)
      MT_MULT:  {hi_out, lo_out} = prod_s;
      MT_MULTU: {hi_out, lo_out} = prod_u;
      MT_MADD:  {hi_out, lo_out} = acc + prod_s;
      MT_MADDU: {hi_out, lo_out} = acc + prod_u;
      MT_MSUB:  {hi_out, lo_out} = acc - prod_s;
      MT_DIV: begin
        if (b_zero) begin
          lo_out = 32'hFFFF_FFFF;
          hi_out = a;
        end else if (s_ovf) begin
          lo_out = 32'h8000_0000;
          hi_out = 32'd0;
        end else begin
          lo_out = sq;
          hi_out = sr;
        end
      end
      MT_DIVU: begin
        if (b_zero) begin
          lo_out = 32'hFFFF_FFFF;
          hi_out = a;
        end else begin
          lo_out = uq;
          hi_out = ur;
        end
      end
      default: begin
        hi_out = hi_in;
        lo_out = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO sequencer: fixed-latency mul/div, moves and E-stage stall
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        opValid,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        readReq,
  input  logic        readSel,
  output logic [31:0] readData,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state;
  muldiv_state_t state_next;
  logic [15:0]   counter;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          live;
  logic          accept;
  logic          start;
  logic          done;

  assign live   = opValid && is_known_op(op);
  assign accept = live && (state == ST_IDLE);
  assign start  = accept && is_multicycle_op(op);
  assign done   = (state == ST_RUN) && (counter == 16'd0);

  muldiv_datapath u_datapath (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_in  (hi),
    .lo_in  (lo),
    .hi_out (res_hi),
    .lo_out (res_lo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: start a run on accept, leave it when the countdown hits zero
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: busy follows the RUN state; a held op or read stalls while busy
  always_comb begin
    busy     = (state == ST_RUN);
    stall    = reset && busy && (live || readReq);
    readData = readSel ? hi : lo;
  end

  // Operand latches, countdown and HI/LO writes (moves in IDLE, commit at end of RUN)
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= 16'd0;
      op_q    <= MT_DISABLED;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      if (start) begin
        op_q    <= op;
        a_q     <= operandA;
        b_q     <= operandB;
        counter <= is_div_op(op) ? 16'(DIV_LATENCY - 1) : 16'(MUL_LATENCY - 1);
      end else if (accept && op == MT_SET_HI) begin
        hi <= operandA;
      end else if (accept && op == MT_SET_LO) begin
        lo <= operandA;
      end
      if (state == ST_RUN) begin
        if (done) begin
          hi <= res_hi;
          lo <= res_lo;
        end else begin
          counter <= counter - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for the HI/LO sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = MT_DISABLED;
  logic        opValid = 1'b0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        readReq = 1'b0;
  logic        readSel = 1'b0;
  logic [31:0] readData;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   run_len = 0;

  muldiv_sequencer #(.MUL_LATENCY(5), .DIV_LATENCY(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .opValid  (opValid),
    .operandA (operandA),
    .operandB (operandB),
    .readReq  (readReq),
    .readSel  (readSel),
    .readData (readData),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_op(input string name, input logic [31:0] h, input logic [31:0] l, input int len);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Called at posedge+1; presents the op for one edge and withdraws it.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op       = o;
    opValid  = 1'b1;
    operandA = a;
    operandB = b;
    @(posedge clk); #1;
    op      = MT_DISABLED;
    opValid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for busy to fall", name);
    end
  endtask

  // Monitor: every completed busy run is a commit; compare against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL commit: unexpected commit hi=%h lo=%h", hi, lo);
      end else begin
        e = sb.pop_front();
        check({e.name, " hi"}, hi, e.hi);
        check({e.name, " lo"}, lo, e.lo);
        check({e.name, " busy_len"}, 32'(run_len), 32'(e.len));
      end
      run_len = 0;
    end
  end

  initial begin
    int cnt;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // mult -3 * 7
    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(MT_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle("mult");

    // divu 100 / 7 with an mflo held from the next cycle
    expect_op("divu", 32'd2, 32'd14, 10);
    issue(MT_DIVU, 32'd100, 32'd7);
    readReq = 1'b1;
    readSel = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
    end
    check("divu stall_cycles", 32'(cnt), 32'd10);
    check("divu readData", readData, 32'd14);
    @(posedge clk); #1;
    readReq = 1'b0;
    wait_idle("divu");

    // Signed divide corner cases
    expect_op("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div neg");
    expect_op("div zero", 32'd5, 32'hFFFF_FFFF, 10);
    issue(MT_DIV, 32'd5, 32'd0);
    wait_idle("div zero");
    expect_op("div ovf", 32'd0, 32'h8000_0000, 10);
    issue(MT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div ovf");

    // Moves, then accumulate across the 32-bit boundary
    issue(MT_SET_HI, 32'd1, 32'd0);
    check("mthi hi", hi, 32'd1);
    check("mthi busy", 32'(busy), 32'd0);
    issue(MT_SET_LO, 32'hFFFF_FFFF, 32'd0);
    check("mtlo lo", lo, 32'hFFFF_FFFF);
    expect_op("maddu", 32'd2, 32'd0, 5);
    issue(MT_MADDU, 32'd1, 32'd1);
    wait_idle("maddu");
    expect_op("msub", 32'd1, 32'hFFFF_FFFF, 5);
    issue(MT_MSUB, 32'd1, 32'd1);
    wait_idle("msub");

    // Back-to-back: second mult held while busy, accepted as busy falls
    expect_op("mult b2b1", 32'd0, 32'd6, 5);
    expect_op("mult b2b2", 32'd0, 32'd20, 5);
    issue(MT_MULT, 32'd2, 32'd3);
    op       = MT_MULT;
    opValid  = 1'b1;
    operandA = 32'd4;
    operandB = 32'd5;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
    end
    check("b2b stall_cycles", 32'(cnt), 32'd5);
    @(posedge clk); #1;
    op      = MT_DISABLED;
    opValid = 1'b0;
    check("b2b no_gap busy", 32'(busy), 32'd1);
    wait_idle("b2b");

    // opValid low never accepts
    op       = MT_MULT;
    opValid  = 1'b0;
    operandA = 32'd9;
    operandB = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    check("novalid busy", 32'(busy), 32'd0);
    check("novalid hi", hi, 32'd0);
    check("novalid lo", lo, 32'd20);
    op = MT_DISABLED;

    // Reset in the middle of a divide
    issue(MT_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    readReq = 1'b1;
    @(negedge clk);
    check("rst busy_before", 32'(busy), 32'd1);
    check("rst stall_gated", 32'(stall), 32'd0);
    @(posedge clk); #1;
    readReq = 1'b0;
    reset   = 1'b1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("rst no_commit hi", hi, 32'd0);
    check("rst no_commit lo", lo, 32'd0);

    @(negedge clk);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
